// File: rtl/seq_alu_pkg.sv
// Shared op-code and state encodings for seq_alu, used by both the ALU and the control unit.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_SLT   = 4'd6,
    ALU_SLTU  = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_MUL   = 4'd11,
    ALU_DIVU  = 4'd12,
    ALU_REMU  = 4'd13,
    ALU_RSV14 = 4'd14,
    ALU_RSV15 = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_iterative(alu_op_e op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv_unit.sv
// Iterative unit: shift-add multiply (LSB first) and restoring divide (MSB first), one step per cycle.
module seq_muldiv_unit
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             div_by_zero
);

  logic             busy_q, busy_d;
  alu_op_e          op_q, op_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH:0]   trial;

  always_comb begin
    busy_d = busy_q;
    op_d   = op_q;
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    rem_d  = rem_q;
    // a_q doubles as the quotient shift register during a divide
    trial  = {rem_q, a_q[WIDTH-1]} - {1'b0, b_q};
    if (start) begin
      busy_d = 1'b1;
      op_d   = op;
      cnt_d  = '0;
      a_d    = a;
      b_d    = b;
      acc_d  = '0;
      rem_d  = '0;
    end else if (busy_q) begin
      cnt_d = cnt_q + SHW'(1);
      if (op_q == ALU_MUL) begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d = a_q << 1;
        b_d = b_q >> 1;
      end else if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        a_d   = {a_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = {rem_q[WIDTH-2:0], a_q[WIDTH-1]};
        a_d   = {a_q[WIDTH-2:0], 1'b0};
      end
      if (cnt_q == SHW'(WIDTH - 1)) busy_d = 1'b0;
    end
  end

  // done and result describe the step being taken this cycle, so the caller can register them directly
  assign done        = busy_q && (cnt_q == SHW'(WIDTH - 1));
  assign div_by_zero = (op_q != ALU_MUL) && (b_q == '0);

  always_comb begin
    case (op_q)
      ALU_MUL:  result = acc_d;
      ALU_DIVU: result = a_d;
      default:  result = rem_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      op_q   <= ALU_ADD;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      rem_q  <= '0;
    end else begin
      busy_q <= busy_d;
      op_q   <= op_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      rem_q  <= rem_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus iterative MUL/DIVU/REMU, result held until consumed.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] left_operand,
  input  logic [WIDTH-1:0] right_operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             div_by_zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dbz_q, dbz_d;

  alu_op_e          op;
  logic             md_start, md_done, md_dbz;
  logic [WIDTH-1:0] md_result;
  logic [WIDTH-1:0] diff, single_res;
  logic [SHW-1:0]   shamt;
  logic             ovf, lt_s, lt_u;

  assign op       = alu_op_e'(alu_op);
  assign shamt    = left_operand[SHW-1:0];
  assign diff     = left_operand - right_operand;
  // signed less-than is the difference sign corrected by overflow
  assign ovf      = (left_operand[WIDTH-1] != right_operand[WIDTH-1]) &&
                    (diff[WIDTH-1] != left_operand[WIDTH-1]);
  assign lt_s     = diff[WIDTH-1] ^ ovf;
  assign lt_u     = left_operand < right_operand;
  assign md_start = (state_q == IDLE) && in_valid && is_iterative(op);

  always_comb begin
    case (op)
      ALU_ADD:  single_res = left_operand + right_operand;
      ALU_SUB:  single_res = diff;
      ALU_AND:  single_res = left_operand & right_operand;
      ALU_OR:   single_res = left_operand | right_operand;
      ALU_XOR:  single_res = left_operand ^ right_operand;
      ALU_NOR:  single_res = ~(left_operand | right_operand);
      ALU_SLT:  single_res = {{(WIDTH-1){1'b0}}, lt_s};
      ALU_SLTU: single_res = {{(WIDTH-1){1'b0}}, lt_u};
      ALU_SLL:  single_res = right_operand << shamt;
      ALU_SRL:  single_res = right_operand >> shamt;
      ALU_SRA:  single_res = $signed(right_operand) >>> shamt;
      default:  single_res = '0;
    endcase
  end

  seq_muldiv_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
    .clk         (clk),
    .rst         (rst),
    .start       (md_start),
    .op          (op),
    .a           (left_operand),
    .b           (right_operand),
    .result      (md_result),
    .done        (md_done),
    .div_by_zero (md_dbz)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dbz_d = 1'b0;
          if (is_iterative(op)) begin
            state_d = BUSY;
          end else begin
            result_d = single_res;
            state_d  = DONE;
          end
        end
      end
      BUSY: begin
        if (md_done) begin
          result_d = md_result;
          dbz_d    = md_dbz;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign alu_result  = result_q;
  assign zero        = (result_q == '0);
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32 and WIDTH=8 with hand-computed expected values.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  alu_op;
  logic        out_ready;
  logic        in_valid32, in_ready32, out_valid32, zero32, dbz32;
  logic [31:0] a32, b32, res32;
  logic        in_valid8, in_ready8, out_valid8, zero8, dbz8;
  logic [7:0]  a8, b8, res8;

  int n_checks = 0;
  int n_fail   = 0;

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .alu_op(alu_op),
    .left_operand(a32), .right_operand(b32), .out_valid(out_valid32), .out_ready(out_ready),
    .alu_result(res32), .zero(zero32), .div_by_zero(dbz32)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .alu_op(alu_op),
    .left_operand(a8), .right_operand(b8), .out_valid(out_valid8), .out_ready(out_ready),
    .alu_result(res8), .zero(zero8), .div_by_zero(dbz8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs_res(input bit w8);
    return w8 ? 64'(res8) : 64'(res32);
  endfunction
  function automatic logic obs_valid(input bit w8);
    return w8 ? out_valid8 : out_valid32;
  endfunction
  function automatic logic obs_ready(input bit w8);
    return w8 ? in_ready8 : in_ready32;
  endfunction
  function automatic logic obs_zero(input bit w8);
    return w8 ? zero8 : zero32;
  endfunction
  function automatic logic obs_dbz(input bit w8);
    return w8 ? dbz8 : dbz32;
  endfunction

  task automatic set_valid(input bit w8, input logic v);
    if (w8) in_valid8 = v;
    else    in_valid32 = v;
  endtask

  // Issue one op, count edges from acceptance to out_valid, optionally back-pressure, then consume.
  task automatic run_op(input string tag, input bit w8, input logic [3:0] op,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp_res,
                        input int exp_lat, input logic exp_dbz, input int hold);
    int lat;
    out_ready = (hold == 0);
    alu_op = op;
    a32 = a[31:0]; b32 = b[31:0];
    a8  = a[7:0];  b8  = b[7:0];
    set_valid(w8, 1'b1);
    check({tag, "/in_ready_idle"}, 64'(obs_ready(w8)), 64'(1));
    @(posedge clk); #1;
    set_valid(w8, 1'b0);
    lat = 1;
    while (!obs_valid(w8) && lat < 200) begin
      check({tag, "/in_ready_busy"}, 64'(obs_ready(w8)), 64'(0));
      alu_op = 4'($urandom_range(0, 15));
      a32 = $urandom; b32 = $urandom;
      a8 = 8'($urandom); b8 = 8'($urandom);
      set_valid(w8, 1'b1);
      @(posedge clk); #1;
      set_valid(w8, 1'b0);
      lat++;
    end
    $display("op %s: lat=%0d result=0x%0h zero=%0b dbz=%0b", tag, lat, obs_res(w8),
             obs_zero(w8), obs_dbz(w8));
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/result"}, obs_res(w8), exp_res);
    check({tag, "/zero"}, 64'(obs_zero(w8)), 64'(exp_res == 64'd0));
    check({tag, "/dbz"}, 64'(obs_dbz(w8)), 64'(exp_dbz));
    check({tag, "/in_ready_done"}, 64'(obs_ready(w8)), 64'(0));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "/hold_valid"}, 64'(obs_valid(w8)), 64'(1));
      check({tag, "/hold_result"}, obs_res(w8), exp_res);
      check({tag, "/hold_zero"}, 64'(obs_zero(w8)), 64'(exp_res == 64'd0));
      check({tag, "/hold_in_ready"}, 64'(obs_ready(w8)), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "/consumed_valid"}, 64'(obs_valid(w8)), 64'(0));
    check({tag, "/consumed_ready"}, 64'(obs_ready(w8)), 64'(1));
  endtask

  initial begin
    logic seen;
    rst = 1'b1; in_valid32 = 1'b0; in_valid8 = 1'b0; out_ready = 1'b0;
    alu_op = 4'd0; a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/out_valid", 64'(out_valid32), 64'(0));
    check("rst/in_ready", 64'(in_ready32), 64'(1));
    check("rst/zero", 64'(zero32), 64'(1));
    check("rst/result", 64'(res32), 64'(0));
    check("rst/dbz", 64'(dbz32), 64'(0));
    check("rst8/in_ready", 64'(in_ready8), 64'(1));
    rst = 1'b0;

    run_op("add_ovf",  0, ALU_ADD,  64'h7FFFFFFF, 64'h1,        64'h80000000, 1, 1'b0, 0);
    run_op("sub_wrap", 0, ALU_SUB,  64'h0,        64'h1,        64'hFFFFFFFF, 1, 1'b0, 0);
    run_op("nor",      0, ALU_NOR,  64'h0,        64'h0,        64'hFFFFFFFF, 1, 1'b0, 0);
    run_op("xor",      0, ALU_XOR,  64'hF0F0F0F0, 64'hFF00FF00, 64'h0FF00FF0, 1, 1'b0, 0);
    run_op("slt_min",  0, ALU_SLT,  64'h80000000, 64'h1,        64'h1,        1, 1'b0, 0);
    run_op("slt_ovf",  0, ALU_SLT,  64'h7FFFFFFF, 64'hFFFFFFFF, 64'h0,        1, 1'b0, 0);
    run_op("sltu",     0, ALU_SLTU, 64'h7FFFFFFF, 64'hFFFFFFFF, 64'h1,        1, 1'b0, 0);
    run_op("sra",      0, ALU_SRA,  64'h4,        64'hF0000000, 64'hFF000000, 1, 1'b0, 0);
    run_op("srl",      0, ALU_SRL,  64'h4,        64'hF0000000, 64'h0F000000, 1, 1'b0, 0);
    run_op("sll_mask", 0, ALU_SLL,  64'h25,       64'h1,        64'h20,       1, 1'b0, 0);
    run_op("rsv14",    0, 4'd14,    64'h12345678, 64'h9,        64'h0,        1, 1'b0, 0);
    run_op("mul",      0, ALU_MUL,  64'hFFFFFFFF, 64'h3,        64'hFFFFFFFD, 33, 1'b0, 0);
    run_op("divu",     0, ALU_DIVU, 64'd100,      64'd7,        64'd14,       33, 1'b0, 0);
    run_op("remu",     0, ALU_REMU, 64'd100,      64'd7,        64'd2,        33, 1'b0, 0);
    run_op("divu_z",   0, ALU_DIVU, 64'd5,        64'd0,        64'hFFFFFFFF, 33, 1'b1, 0);
    run_op("remu_z",   0, ALU_REMU, 64'd5,        64'd0,        64'd5,        33, 1'b1, 0);
    run_op("add_zero", 0, ALU_ADD,  64'd0,        64'd0,        64'd0,        1, 1'b0, 0);
    run_op("bp_divu",  0, ALU_DIVU, 64'd100,      64'd7,        64'd14,       33, 1'b0, 5);

    // reset during a divide discards it
    out_ready = 1'b1;
    alu_op = ALU_DIVU; a32 = 32'd100; b32 = 32'd7; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("op rst_mid: in_ready=%0b out_valid=%0b", in_ready32, out_valid32);
    check("rst_mid/in_ready", 64'(in_ready32), 64'(1));
    check("rst_mid/out_valid", 64'(out_valid32), 64'(0));
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | out_valid32;
    end
    check("rst_mid/no_output", 64'(seen), 64'(0));

    run_op("mul8",    1, ALU_MUL,  64'hFF,  64'h3,  64'hFD, 9, 1'b0, 0);
    run_op("divu8",   1, ALU_DIVU, 64'd100, 64'd7,  64'd14, 9, 1'b0, 0);
    run_op("remu8",   1, ALU_REMU, 64'd100, 64'd7,  64'd2,  9, 1'b0, 0);
    run_op("divu8_z", 1, ALU_DIVU, 64'd5,   64'd0,  64'hFF, 9, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
